// File: rtl/riscv_alumux_fwd.sv
// riscv_alumux_fwd: ALU operand-B mux with EX/MEM and MEM/WB forwarding,
// behind a single valid/ready output register stage.
// Optional forwarding statistics counter: define RISCV_ALUMUX_FWD_STATS_EN.
module riscv_alumux_fwd #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic                  bsel,
   input  logic                  exm_wen,
   input  logic [REG_ADDR_W-1:0] exm_rd,
   input  logic [DATA_WIDTH-1:0] exm_data,
   input  logic                  mwb_wen,
   input  logic [REG_ADDR_W-1:0] mwb_rd,
   input  logic [DATA_WIDTH-1:0] mwb_data,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] alumux2_out,
   output logic [1:0]            fwd_src
`ifdef RISCV_ALUMUX_FWD_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]  fwd_cnt
`endif
);

   localparam logic [1:0] SRC_RF  = 2'd0;
   localparam logic [1:0] SRC_EXM = 2'd1;
   localparam logic [1:0] SRC_MWB = 2'd2;

   // Reject degenerate configurations at elaboration time.
   if (DATA_WIDTH < 1 || REG_ADDR_W < 1 || CNT_WIDTH < 1) begin : g_bad_cfg
      $error("riscv_alumux_fwd: all widths must be at least 1");
   end

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [1:0]            src_q, src_d;
   logic [DATA_WIDTH-1:0] op_sel;
   logic [1:0]            src_sel;
   logic                  transfer;

   assign in_ready    = !valid_q || out_ready;
   assign transfer    = in_valid && in_ready;
   assign out_valid   = valid_q;
   assign alumux2_out = data_q;
   assign fwd_src     = src_q;

   // Operand selection; x0 never forwards and any bsel other than 1 means register.
   always_comb begin
      op_sel  = rs2_data;
      src_sel = SRC_RF;
      if (bsel == 1'b1) begin
         op_sel = imm;
      end else if (rs2_addr != '0) begin
         if (exm_wen && (exm_rd == rs2_addr)) begin
            op_sel  = exm_data;
            src_sel = SRC_EXM;
         end else if (mwb_wen && (mwb_rd == rs2_addr)) begin
            op_sel  = mwb_data;
            src_sel = SRC_MWB;
         end
      end
   end

   // Output stage next state: capture on transfer, drain on ready, flush kills valid.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      src_d   = src_q;
      if (transfer) begin
         valid_d = 1'b1;
         data_d  = op_sel;
         src_d   = src_sel;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
      if (flush) begin
         valid_d = 1'b0;
      end
   end

   // Output register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= SRC_RF;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

`ifdef RISCV_ALUMUX_FWD_STATS_EN
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   assign fwd_cnt = cnt_q;

   // Saturating count of forwarded transfers; flush does not affect it.
   always_comb begin
      cnt_d = cnt_q;
      if (transfer && (src_sel != SRC_RF) && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

endmodule
